// File: rtl/i2c_arb_pkg.sv
// Shared types and widths for the I2C request arbiter: status codes,
// controller state encoding and command field widths.
package i2c_arb_pkg;

  localparam int DEV_ADDR_W = 7;
  localparam int REG_NUM_W  = 16;
  localparam int REG_LEN_W  = 2;
  localparam int LEN_W      = 3;
  localparam int DATA_W     = 32;

  localparam logic [LEN_W-1:0] MAX_LEN = 3'd4;

  typedef enum logic [1:0] {
    ST_OK     = 2'b00,
    ST_FAULT  = 2'b01,
    ST_WDOG   = 2'b10,
    ST_BADLEN = 2'b11
  } status_e;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_CHECK     = 3'd1,
    S_ISSUE     = 3'd2,
    S_WAIT_BUSY = 3'd3,
    S_WAIT_DONE = 3'd4,
    S_RESP      = 3'd5
  } state_e;

  function automatic logic len_ok(input logic [LEN_W-1:0] len);
    return (len != 3'd0) && (len <= MAX_LEN);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first asserted request strictly after ptr,
// wrapping; the pointer register is owned by the caller.
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDX_W-1:0]   grant_idx
);

  // scan NUM_REQ candidates starting one past the pointer
  always_comb begin
    logic             found_s;
    logic             hit_s;
    logic [IDX_W-1:0] cand_s;
    grant     = '0;
    grant_idx = '0;
    found_s   = 1'b0;
    hit_s     = 1'b0;
    cand_s    = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      cand_s        = IDX_W'((int'(ptr) + i) % NUM_REQ);
      hit_s         = req[cand_s] & ~found_s;
      grant[cand_s] = hit_s;
      grant_idx     = hit_s ? cand_s : grant_idx;
      found_s       = found_s | hit_s;
    end
  end

endmodule

// File: rtl/i2c_request_arbiter.sv
// Shares one I2C front-end between NUM_REQ requesters: round-robin grant,
// command latch, single start strobe, busy/done watchdogs and status return.
module i2c_request_arbiter
  import i2c_arb_pkg::*;
#(
  parameter int NUM_REQ     = 4,
  parameter int WDOG_CYCLES = 1000000,
  parameter int BUSY_CYCLES = 64
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [NUM_REQ-1:0]        req_rw,
  input  logic [NUM_REQ*7-1:0]      req_dev_addr,
  input  logic [NUM_REQ*16-1:0]     req_reg_num,
  input  logic [NUM_REQ*2-1:0]      req_reg_num_len,
  input  logic [NUM_REQ*3-1:0]      req_len,
  input  logic [NUM_REQ*32-1:0]     req_tx_data,
  output logic [NUM_REQ-1:0]        rsp_valid,
  output logic [DATA_W-1:0]         rsp_rx_data,
  output logic [1:0]                rsp_status,
  output logic [DEV_ADDR_W-1:0]     o_dev_addr,
  output logic [REG_NUM_W-1:0]      o_reg_num,
  output logic [REG_LEN_W-1:0]      o_reg_num_len,
  output logic [DATA_W-1:0]         o_tx_data,
  output logic [LEN_W-1:0]          o_read_len,
  output logic                      o_read_start,
  output logic [LEN_W-1:0]          o_write_len,
  output logic                      o_write_start,
  input  logic                      i_idle,
  input  logic                      i_fault,
  input  logic [DATA_W-1:0]         i_rx_data
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int CNT_W = $clog2(WDOG_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  state_e                  state_r;
  logic [IDX_W-1:0]        ptr_r;
  logic [NUM_REQ-1:0]      gnt_r;
  logic                    cmd_rw_r;
  logic [DEV_ADDR_W-1:0]   cmd_dev_r;
  logic [REG_NUM_W-1:0]    cmd_reg_r;
  logic [REG_LEN_W-1:0]    cmd_rnl_r;
  logic [LEN_W-1:0]        cmd_len_r;
  logic [DATA_W-1:0]       cmd_tx_r;
  logic [CNT_W-1:0]        cnt_r;
  logic [CNT_W-1:0]        cnt_inc_s;
  logic [NUM_REQ-1:0]      grant_s;
  logic [IDX_W-1:0]        idx_s;
  logic [NUM_REQ-1:0]      grant_now_s;

  rr_arbiter #(.NUM_REQ(NUM_REQ), .IDX_W(IDX_W)) u_rr (
    .req       (req_valid),
    .ptr       (ptr_r),
    .grant     (grant_s),
    .grant_idx (idx_s)
  );

  // accept only while idle with the front-end idle; masked during reset so no request is lost
  always_comb begin
    if ((state_r == S_IDLE) && i_idle && !reset) begin
      grant_now_s = grant_s;
    end else begin
      grant_now_s = '0;
    end
  end

  assign req_ready = grant_now_s;
  assign cnt_inc_s = (cnt_r == CNT_MAX) ? cnt_r : cnt_r + 1'b1;

  // controller: grant, validate, issue, supervise, respond
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r       <= S_IDLE;
      ptr_r         <= IDX_W'(NUM_REQ - 1);
      gnt_r         <= '0;
      cmd_rw_r      <= 1'b0;
      cmd_dev_r     <= '0;
      cmd_reg_r     <= '0;
      cmd_rnl_r     <= '0;
      cmd_len_r     <= '0;
      cmd_tx_r      <= '0;
      cnt_r         <= '0;
      rsp_valid     <= '0;
      rsp_rx_data   <= 32'd0;
      rsp_status    <= ST_OK;
      o_dev_addr    <= '0;
      o_reg_num     <= '0;
      o_reg_num_len <= '0;
      o_tx_data     <= 32'd0;
      o_read_len    <= '0;
      o_read_start  <= 1'b0;
      o_write_len   <= '0;
      o_write_start <= 1'b0;
    end else begin
      o_read_start  <= 1'b0;
      o_write_start <= 1'b0;
      rsp_valid     <= '0;
      case (state_r)
        S_IDLE: begin
          if (|grant_now_s) begin
            gnt_r     <= grant_now_s;
            ptr_r     <= idx_s;
            cmd_rw_r  <= req_rw[idx_s];
            cmd_dev_r <= req_dev_addr[int'(idx_s)*DEV_ADDR_W +: DEV_ADDR_W];
            cmd_reg_r <= req_reg_num[int'(idx_s)*REG_NUM_W +: REG_NUM_W];
            cmd_rnl_r <= req_reg_num_len[int'(idx_s)*REG_LEN_W +: REG_LEN_W];
            cmd_len_r <= req_len[int'(idx_s)*LEN_W +: LEN_W];
            cmd_tx_r  <= req_tx_data[int'(idx_s)*DATA_W +: DATA_W];
            state_r   <= S_CHECK;
          end else begin
            state_r   <= S_IDLE;
          end
        end
        S_CHECK: begin
          if (!len_ok(cmd_len_r)) begin
            rsp_valid   <= gnt_r;
            rsp_status  <= ST_BADLEN;
            rsp_rx_data <= 32'd0;
            state_r     <= S_RESP;
          end else begin
            o_dev_addr    <= cmd_dev_r;
            o_reg_num     <= cmd_reg_r;
            o_reg_num_len <= cmd_rnl_r;
            o_tx_data     <= cmd_tx_r;
            o_read_len    <= cmd_rw_r ? cmd_len_r : 3'd0;
            o_write_len   <= cmd_rw_r ? 3'd0 : cmd_len_r;
            o_read_start  <= cmd_rw_r;
            o_write_start <= ~cmd_rw_r;
            state_r       <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          // counter holds cycles elapsed since the start pulse
          cnt_r   <= CNT_W'(1);
          state_r <= S_WAIT_BUSY;
        end
        S_WAIT_BUSY: begin
          cnt_r <= cnt_inc_s;
          if (!i_idle) begin
            state_r <= S_WAIT_DONE;
          end else if (cnt_r >= CNT_W'(BUSY_CYCLES)) begin
            rsp_valid   <= gnt_r;
            rsp_status  <= ST_WDOG;
            rsp_rx_data <= 32'd0;
            state_r     <= S_RESP;
          end else begin
            state_r <= S_WAIT_BUSY;
          end
        end
        S_WAIT_DONE: begin
          cnt_r <= cnt_inc_s;
          if (i_idle) begin
            rsp_valid   <= gnt_r;
            rsp_status  <= i_fault ? ST_FAULT : ST_OK;
            rsp_rx_data <= cmd_rw_r ? i_rx_data : 32'd0;
            state_r     <= S_RESP;
          end else if (cnt_r >= CNT_W'(WDOG_CYCLES)) begin
            rsp_valid   <= gnt_r;
            rsp_status  <= ST_WDOG;
            rsp_rx_data <= 32'd0;
            state_r     <= S_RESP;
          end else begin
            state_r <= S_WAIT_DONE;
          end
        end
        S_RESP: begin
          state_r <= S_IDLE;
        end
        default: begin
          state_r <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_i2c_request_arbiter.sv
// Self-checking bench for i2c_request_arbiter: vector table plus hand sequences
// for fairness and reset; expected responses flow through a scoreboard queue.
module tb_i2c_request_arbiter;

  localparam int NREQ = 4;
  localparam int WDOG = 100;
  localparam int BUSY = 16;

  logic             clk;
  logic             reset;
  logic [NREQ-1:0]  req_valid;
  logic [NREQ-1:0]  req_ready;
  logic [NREQ-1:0]  req_rw;
  logic [NREQ*7-1:0]  req_dev_addr;
  logic [NREQ*16-1:0] req_reg_num;
  logic [NREQ*2-1:0]  req_reg_num_len;
  logic [NREQ*3-1:0]  req_len;
  logic [NREQ*32-1:0] req_tx_data;
  logic [NREQ-1:0]  rsp_valid;
  logic [31:0]      rsp_rx_data;
  logic [1:0]       rsp_status;
  logic [6:0]       o_dev_addr;
  logic [15:0]      o_reg_num;
  logic [1:0]       o_reg_num_len;
  logic [31:0]      o_tx_data;
  logic [2:0]       o_read_len;
  logic             o_read_start;
  logic [2:0]       o_write_len;
  logic             o_write_start;
  logic             i_idle;
  logic             i_fault;
  logic [31:0]      i_rx_data;

  i2c_request_arbiter #(.NUM_REQ(NREQ), .WDOG_CYCLES(WDOG), .BUSY_CYCLES(BUSY)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_rw(req_rw),
    .req_dev_addr(req_dev_addr), .req_reg_num(req_reg_num),
    .req_reg_num_len(req_reg_num_len), .req_len(req_len), .req_tx_data(req_tx_data),
    .rsp_valid(rsp_valid), .rsp_rx_data(rsp_rx_data), .rsp_status(rsp_status),
    .o_dev_addr(o_dev_addr), .o_reg_num(o_reg_num), .o_reg_num_len(o_reg_num_len),
    .o_tx_data(o_tx_data), .o_read_len(o_read_len), .o_read_start(o_read_start),
    .o_write_len(o_write_len), .o_write_start(o_write_start),
    .i_idle(i_idle), .i_fault(i_fault), .i_rx_data(i_rx_data)
  );

  typedef struct {
    int          idx;
    logic        rw;
    logic [6:0]  dev;
    logic [15:0] regn;
    logic [1:0]  rnl;
    logic [2:0]  len;
    logic [31:0] tx;
    logic [31:0] rx;      // front-end read data returned
    logic        flt;     // front-end fault at completion
    int          mode;    // 0 normal, 1 idle stuck low, 2 idle never drops
    logic        exp_start;
    logic [1:0]  exp_status;
    logic [31:0] exp_rx;
  } vec_t;

  typedef struct {
    logic [NREQ-1:0] onehot;
    logic [1:0]      status;
    logic [31:0]     rx;
    int              lat_start;  // start pulse to rsp_valid, -1 = not checked
    int              lat_ready;  // req_ready to rsp_valid, -1 = not checked
  } rsp_t;

  rsp_t sb_q[$];
  vec_t cmd_q[$];
  int   grant_log[$];
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  int   ready_cyc = 0;
  int   start_cyc = 0;
  int   fe_mode = 0;
  logic fe_fault = 1'b0;
  logic [31:0] fe_rx = 32'd0;
  int   fe_t = -1;
  vec_t vecs[9];

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // front-end model: idle drops 3 cycles after a start, returns 4 cycles later
  initial begin
    i_idle = 1'b1; i_fault = 1'b0; i_rx_data = 32'd0;
    forever begin
      @(posedge clk); #1;
      if (reset || (|rsp_valid)) begin
        i_idle = 1'b1; fe_t = -1;
      end else if (o_read_start || o_write_start) begin
        fe_t = 0;
      end else if (fe_t >= 0) begin
        fe_t++;
        if (fe_t == 3 && fe_mode != 2) i_idle = 1'b0;
        if (fe_t == 7 && fe_mode == 0) begin
          i_idle = 1'b1; i_fault = fe_fault; i_rx_data = fe_rx; fe_t = -1;
        end
      end
    end
  end

  // monitor: grants, start pulses against expected commands, responses against scoreboard
  always @(negedge clk) begin
    vec_t c;
    rsp_t e;
    if (|req_ready) begin
      ready_cyc = cyc;
      check("ready_onehot", 64'($onehot(req_ready)), 64'd1);
      for (int k = 0; k < NREQ; k++) if (req_ready[k]) grant_log.push_back(k);
    end
    if (o_read_start || o_write_start) begin
      start_cyc = cyc;
      check("ready_to_start", 64'(cyc - ready_cyc), 64'd2);
      if (cmd_q.size() == 0) begin
        check("unexpected_start", 64'd1, 64'd0);
      end else begin
        c = cmd_q.pop_front();
        check("start_kind", {o_read_start, o_write_start}, c.rw ? 2'b10 : 2'b01);
        check("o_dev_addr", o_dev_addr, c.dev);
        check("o_reg_num", o_reg_num, c.regn);
        check("o_reg_num_len", o_reg_num_len, c.rnl);
        check("o_len", c.rw ? o_read_len : o_write_len, c.len);
        if (!c.rw) check("o_tx_data", o_tx_data, c.tx);
      end
    end
    if (|rsp_valid) begin
      if (sb_q.size() == 0) begin
        check("unexpected_rsp", rsp_valid, 64'd0);
      end else begin
        e = sb_q.pop_front();
        check("rsp_valid", rsp_valid, e.onehot);
        check("rsp_status", rsp_status, e.status);
        check("rsp_rx_data", rsp_rx_data, e.rx);
        if (e.lat_start >= 0) check("start_to_rsp", 64'(cyc - start_cyc), 64'(e.lat_start));
        if (e.lat_ready >= 0) check("ready_to_rsp", 64'(cyc - ready_cyc), 64'(e.lat_ready));
      end
    end
  end

  task automatic set_req(input vec_t v);
    req_rw[v.idx]                 = v.rw;
    req_dev_addr[v.idx*7 +: 7]    = v.dev;
    req_reg_num[v.idx*16 +: 16]   = v.regn;
    req_reg_num_len[v.idx*2 +: 2] = v.rnl;
    req_len[v.idx*3 +: 3]         = v.len;
    req_tx_data[v.idx*32 +: 32]   = v.tx;
  endtask

  function automatic rsp_t exp_of(input vec_t v);
    rsp_t e;
    e.onehot    = NREQ'(1) << v.idx;
    e.status    = v.exp_status;
    e.rx        = v.exp_rx;
    e.lat_ready = v.exp_start ? -1 : 2;
    e.lat_start = !v.exp_start ? -1 : (v.mode == 0) ? 8 : (v.mode == 1) ? WDOG + 1 : BUSY + 1;
    return e;
  endfunction

  task automatic wait_ready(output logic [NREQ-1:0] got);
    got = '0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (|req_ready) begin
        got = req_ready;
        break;
      end
    end
    check("ready_seen", 64'(|got), 64'd1);
    @(posedge clk); #1;
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 400; i++) begin
      @(posedge clk);
      if (sb_q.size() == 0) break;
    end
    check("rsp_pending", 64'(sb_q.size()), 64'd0);
    sb_q.delete();
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic run_vec(input vec_t v);
    logic [NREQ-1:0] got;
    fe_mode = v.mode; fe_fault = v.flt; fe_rx = v.rx;
    set_req(v);
    sb_q.push_back(exp_of(v));
    if (v.exp_start) cmd_q.push_back(v);
    req_valid[v.idx] = 1'b1;
    wait_ready(got);
    check("grant_sel", got, NREQ'(1) << v.idx);
    req_valid[v.idx] = 1'b0;
    wait_drain();
    if (v.exp_start) check("o_dev_hold", o_dev_addr, v.dev);
    cmd_q.delete();
  endtask

  task automatic check_all_zero(input string name);
    check(name, {req_ready, rsp_valid, rsp_rx_data, rsp_status, o_dev_addr, o_reg_num,
                 o_reg_num_len, o_read_len, o_read_start, o_write_len, o_write_start}, 64'd0);
    check({name, "_tx"}, o_tx_data, 32'd0);
  endtask

  initial begin
    #2000000;
    $display("FAIL global_timeout actual=%0d required=finished", cyc);
    $fatal(1);
  end

  initial begin
    logic [NREQ-1:0] got;
    vec_t w;
    vecs[0] = '{0, 1'b1, 7'h50, 16'h0012, 2'd1, 3'd2, 32'h0, 32'h0000ABCD, 1'b0, 0, 1'b1, 2'b00, 32'h0000ABCD};
    vecs[1] = '{1, 1'b0, 7'h21, 16'h0304, 2'd2, 3'd4, 32'hDEADBEEF, 32'h11111111, 1'b1, 0, 1'b1, 2'b01, 32'h0};
    vecs[2] = '{2, 1'b1, 7'h33, 16'h0040, 2'd1, 3'd0, 32'h0, 32'h0, 1'b0, 0, 1'b0, 2'b11, 32'h0};
    vecs[3] = '{2, 1'b0, 7'h33, 16'h0041, 2'd1, 3'd5, 32'h01020304, 32'h0, 1'b0, 0, 1'b0, 2'b11, 32'h0};
    vecs[4] = '{2, 1'b1, 7'h44, 16'h0100, 2'd2, 3'd3, 32'h0, 32'h000055AA, 1'b1, 0, 1'b1, 2'b01, 32'h000055AA};
    vecs[5] = '{3, 1'b1, 7'h7F, 16'hFFFF, 2'd0, 3'd4, 32'h0, 32'h12345678, 1'b0, 0, 1'b1, 2'b00, 32'h12345678};
    vecs[6] = '{1, 1'b1, 7'h0A, 16'h0002, 2'd1, 3'd7, 32'h0, 32'h0, 1'b0, 0, 1'b0, 2'b11, 32'h0};
    vecs[7] = '{3, 1'b1, 7'h12, 16'h0010, 2'd1, 3'd1, 32'h0, 32'hCAFE0000, 1'b0, 1, 1'b1, 2'b10, 32'h0};
    vecs[8] = '{0, 1'b0, 7'h13, 16'h0020, 2'd1, 3'd1, 32'h000000A5, 32'h0, 1'b0, 2, 1'b1, 2'b10, 32'h0};

    reset = 1'b1; req_valid = '0; req_rw = '0; req_dev_addr = '0; req_reg_num = '0;
    req_reg_num_len = '0; req_len = '0; req_tx_data = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check_all_zero("reset_state");
    @(posedge clk); #1;

    // fairness: all four held valid, pointer starts at NREQ-1
    grant_log.delete();
    for (int k = 0; k < NREQ; k++) begin
      w = '{k, 1'b0, 7'(7'h10 + k), 16'(k), 2'd1, 3'd1, 32'(k), 32'h0, 1'b0, 0, 1'b1, 2'b00, 32'h0};
      set_req(w);
    end
    for (int n = 0; n < 6; n++) begin
      w = '{n % NREQ, 1'b0, 7'(7'h10 + n % NREQ), 16'(n % NREQ), 2'd1, 3'd1, 32'(n % NREQ),
            32'h0, 1'b0, 0, 1'b1, 2'b00, 32'h0};
      sb_q.push_back(exp_of(w));
      cmd_q.push_back(w);
    end
    fe_mode = 0; fe_fault = 1'b0;
    req_valid = '1;
    for (int n = 0; n < 6; n++) wait_ready(got);
    req_valid = '0;
    wait_drain();
    check("fair_count", 64'(grant_log.size()), 64'd6);
    for (int n = 0; n < 6 && n < grant_log.size(); n++)
      check("fair_order", 64'(grant_log[n]), 64'(n % NREQ));
    cmd_q.delete();

    for (int i = 0; i < 9; i++) run_vec(vecs[i]);

    // reset while waiting for completion: silent abort, pointer back to NREQ-1
    w = '{0, 1'b1, 7'h66, 16'h0077, 2'd1, 3'd2, 32'h0, 32'h0, 1'b0, 1, 1'b1, 2'b00, 32'h0};
    fe_mode = 1; set_req(w); cmd_q.push_back(w);
    req_valid[0] = 1'b1;
    wait_ready(got);
    req_valid[0] = 1'b0;
    repeat (12) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check_all_zero("reset_abort");
    @(posedge clk); #1 reset = 1'b0;
    fe_mode = 0;
    repeat (3) @(posedge clk);
    #1;
    w = '{0, 1'b0, 7'h01, 16'h0001, 2'd1, 3'd1, 32'h0000AAAA, 32'h0, 1'b0, 0, 1'b1, 2'b00, 32'h0};
    set_req(w); sb_q.push_back(exp_of(w)); cmd_q.push_back(w);
    w = '{1, 1'b0, 7'h02, 16'h0002, 2'd1, 3'd2, 32'h0000BBBB, 32'h0, 1'b0, 0, 1'b1, 2'b00, 32'h0};
    set_req(w); sb_q.push_back(exp_of(w)); cmd_q.push_back(w);
    req_valid[1:0] = 2'b11;
    wait_ready(got);
    check("post_reset_first", got, 4'b0001);
    req_valid[0] = 1'b0;
    wait_ready(got);
    check("post_reset_second", got, 4'b0010);
    req_valid[1] = 1'b0;
    wait_drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
